alu_mul_seq: RTL and testbench

- Multi-cycle 16x16 -> 32-bit multiply sequencer built on the shared 16-bit ALU, using shift-and-add.
- Drives the ALU input ports (A, B, Cin, Op, invA, invB, sign) and consumes its Out and Ofl; the ALU instance sits outside this block.
- Valid/ready handshake on the operand side and on the result side; one operation in flight at a time.

---
 rtl/alu_mul_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_mul_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 16x16->32 multiply sequencer driving an external ALU.
// Ports: clk, rst_n (sync), in_valid/in_ready/a/b/in_signed, out_valid/out_ready/product, alu_* bus. Macro: ALU_MUL_SEQ_SIGNED_EN.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   alu_A,
  output logic [WIDTH-1:0]   alu_B,
  output logic               alu_Cin,
  output logic [2:0]         alu_Op,
  output logic               alu_invA,
  output logic               alu_invB,
  output logic               alu_sign,
  input  logic [WIDTH-1:0]   alu_Out,
  input  logic               alu_Ofl
);

  localparam int CW = $clog2(WIDTH);

`ifdef ALU_MUL_SEQ_SIGNED_EN
  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DONE,
    S_NEGA, S_NEGB, S_NEGLO, S_NEGHI
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DONE
  } state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;

`ifdef ALU_MUL_SEQ_SIGNED_EN
  logic neg_res;
  logic a_neg;
  logic b_neg;
  logic carry;
`else
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
`endif

  assign in_ready = (state == S_IDLE);
  assign product  = {hi, lo};

  always_comb begin
    alu_A    = '0;
    alu_B    = '0;
    alu_Cin  = 1'b0;
    alu_Op   = 3'b000;
    alu_invA = 1'b0;
    alu_invB = 1'b0;
    alu_sign = 1'b0;
    unique case (state)
      S_MUL: begin
        alu_A = hi;
        alu_B = lo[0] ? m : '0;
      end
`ifdef ALU_MUL_SEQ_SIGNED_EN
      S_NEGA: begin
        alu_A    = lo;
        alu_invA = 1'b1;
        alu_Cin  = 1'b1;
      end
      S_NEGB: begin
        alu_A    = m;
        alu_invA = 1'b1;
        alu_Cin  = 1'b1;
      end
      S_NEGLO: begin
        alu_A    = lo;
        alu_invA = 1'b1;
        alu_Cin  = 1'b1;
      end
      S_NEGHI: begin
        alu_A    = hi;
        alu_invA = 1'b1;
        alu_Cin  = carry;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      m         <= '0;
      out_valid <= 1'b0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      neg_res   <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      carry     <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            lo  <= a;
            m   <= b;
            hi  <= '0;
            cnt <= '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
            neg_res <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            a_neg   <= in_signed & a[WIDTH-1];
            b_neg   <= in_signed & b[WIDTH-1];
            state   <= in_signed ? S_NEGA : S_MUL;
`else
            state   <= S_MUL;
`endif
          end
        end
        S_MUL: begin
          // {carry, sum, lo} shifted right by one; carry lands in hi MSB
          hi  <= {alu_Ofl, alu_Out[WIDTH-1:1]};
          lo  <= {alu_Out[0], lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
`ifdef ALU_MUL_SEQ_SIGNED_EN
            if (neg_res) begin
              state <= S_NEGLO;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end
`else
            state     <= S_DONE;
            out_valid <= 1'b1;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
`ifdef ALU_MUL_SEQ_SIGNED_EN
        S_NEGA: begin
          if (a_neg) lo <= alu_Out;
          state <= S_NEGB;
        end
        S_NEGB: begin
          if (b_neg) m <= alu_Out;
          state <= S_MUL;
        end
        S_NEGLO: begin
          lo    <= alu_Out;
          carry <= alu_Ofl;
          state <= S_NEGHI;
        end
        S_NEGHI: begin
          hi        <= alu_Out;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: scoreboard bench for alu_mul_seq with a behavioural ALU.
// Random and directed multiplies compared against plain-arithmetic products and latencies.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic [15:0] alu_A;
  logic [15:0] alu_B;
  logic        alu_Cin;
  logic [2:0]  alu_Op;
  logic        alu_invA;
  logic        alu_invB;
  logic        alu_sign;
  logic [15:0] alu_Out;
  logic        alu_Ofl;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin),
    .alu_Op(alu_Op), .alu_invA(alu_invA),
    .alu_invB(alu_invB), .alu_sign(alu_sign),
    .alu_Out(alu_Out), .alu_Ofl(alu_Ofl)
  );

  // ALU: ADD with optional input inversion, carry-out as Ofl
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, (alu_invA ? ~alu_A : alu_A)}
            + {1'b0, (alu_invB ? ~alu_B : alu_B)}
            + {16'd0, alu_Cin};
    alu_Out = alu_sum[15:0];
    alu_Ofl = alu_sum[16];
  end

  typedef struct {
    logic [31:0] p;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, expv);
    end
  endtask

  function automatic exp_t ref_op(input logic [15:0] x,
                                  input logic [15:0] y,
                                  input logic s);
    exp_t   e;
    longint xv;
    longint yv;
    logic   sg;
`ifdef ALU_MUL_SEQ_SIGNED_EN
    sg = s;
`else
    sg = 1'b0;
`endif
    xv = sg ? longint'($signed(x)) : longint'(x);
    yv = sg ? longint'($signed(y)) : longint'(y);
    e.p = 32'(xv * yv);
    if (!sg) e.lat = 17;
    else if (x[15] != y[15]) e.lat = 21;
    else e.lat = 19;
    e.acc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    unique case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic        seen = 1'b0;
  logic [31:0] held;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (!seen) begin
        seen = 1'b1;
        held = product;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %h expected none", product);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", product, e.p);
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end else begin
        chk("product_hold", product, held);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y,
                       input logic s, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got in_ready=%b expected 1", in_ready);
      return;
    end
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    in_signed = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e = ref_op(x, y, s);
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_alu", {3'd0, alu_A, alu_B[12:0]}, 32'd0);
    chk("rst_alu_ctl", {22'd0, alu_B[15:13], alu_Cin, alu_Op,
                        alu_invA, alu_invB, alu_sign}, 32'd0);
    rst_n = 1'b1;

    issue(16'd3, 16'd5, 1'b0, 1'b1);
    drain();

    rdy_mode = 1;
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("max_valid", {31'd0, out_valid}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
    end
    rdy_mode = 0;
    drain();
    repeat (25) @(negedge clk);
    chk("idle_after_stall", {31'd0, in_ready}, 32'd1);

    issue(16'h1234, 16'h0010, 1'b0, 1'b1);
    issue(16'h00FF, 16'h0100, 1'b0, 1'b1);
    drain();

    issue(16'd5, 16'd6, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (25) @(negedge clk);
    issue(16'd7, 16'd9, 1'b0, 1'b1);
    drain();

`ifdef ALU_MUL_SEQ_SIGNED_EN
    issue(16'hFFFD, 16'h0005, 1'b1, 1'b1);
    issue(16'h8000, 16'h8000, 1'b1, 1'b1);
    issue(16'hFFFD, 16'h0005, 1'b0, 1'b1);
    issue(16'h8000, 16'h8000, 1'b0, 1'b1);
    drain();
`endif

    issue(16'd0, 16'hABCD, 1'b0, 1'b1);
    issue(16'h1357, 16'd0, 1'b1, 1'b1);
    rdy_mode = 2;
    for (int i = 0; i < 24; i++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
